// File: rtl/trace_pattern_gen.sv
// Trace pattern generator: emits one pattern word per DIVISOR-clock slot over an
// active-low valid / active-high ready handshake, counting slots the consumer missed.
module trace_pattern_gen #(
  parameter int          OUTPUT_BUS_WIDTH = 8,
  parameter int          CLOCKFRQ         = 240000000,
  parameter int          DIVISOR          = CLOCKFRQ / 10,
  parameter logic [31:0] LFSR_SEED        = 32'h0000_0001
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic                        dReady,
  output logic                        nDValid,
  output logic [OUTPUT_BUS_WIDTH-1:0] dOut,
  output logic [15:0]                 dropCount
);

  localparam int W  = OUTPUT_BUS_WIDTH;
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  word_q, word_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          ndv_q, ndv_d;
  logic [15:0]   drop_q, drop_d;
  logic          tick_s;
  logic [CW-1:0] cnt_step_s;
  logic [W-1:0]  cur_word_s;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [W-1:0] ascii_next(input logic [W-1:0] c);
    logic [W-1:0] n;
    if (c == W'(8'd90)) begin
      n = W'(8'd10);
    end else if (c == W'(8'd10)) begin
      n = W'(8'd13);
    end else if (c == W'(8'd13)) begin
      n = W'(8'd65);
    end else begin
      n = c + W'(1'b1);
    end
    return n;
  endfunction

  function automatic logic [W-1:0] start_word(input logic [1:0] md);
    logic [W-1:0] s;
    case (md)
      2'd0:    s = W'(8'd65);
      2'd3:    s = W'(1'b1);
      default: s = {W{1'b0}};
    endcase
    return s;
  endfunction

  function automatic logic [W-1:0] next_word(input logic [1:0] md, input logic [W-1:0] w);
    logic [W-1:0] n;
    case (md)
      2'd0:    n = ascii_next(w);
      2'd1:    n = w + W'(1'b1);
      2'd3:    n = {w[W-2:0], w[W-1]};
      default: n = w;
    endcase
    return n;
  endfunction

  assign tick_s     = (cnt_q == CNT_LAST);
  assign cnt_step_s = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
  // PRBS words come straight from the shift register; other modes keep their own word.
  assign cur_word_s = (mode_q == 2'd2) ? lfsr_q[W-1:0] : word_q;

  // Next-state, slot timing, handshake and drop accounting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    word_d  = word_q;
    lfsr_d  = lfsr_q;
    dout_d  = dout_q;
    ndv_d   = ndv_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        ndv_d = 1'b1;
        cnt_d = {CW{1'b0}};
        if (enable) begin
          mode_d  = mode;
          word_d  = start_word(mode);
          lfsr_d  = LFSR_SEED;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
          ndv_d   = 1'b1;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_step_s;
          if (tick_s) begin
            dout_d  = cur_word_s;
            ndv_d   = 1'b0;
            state_d = S_PRESENT;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_PRESENT: begin
        if (!enable) begin
          state_d = S_IDLE;
          ndv_d   = 1'b1;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_step_s;
          // A transfer on a tick edge consumes that slot, so it is never a drop.
          if (dReady) begin
            ndv_d   = 1'b1;
            state_d = S_WAIT;
            if (mode_q == 2'd2) begin
              lfsr_d = lfsr_next(lfsr_q);
            end else begin
              word_d = next_word(mode_q, word_q);
            end
          end else if (tick_s) begin
            if (drop_q != 16'hFFFF) begin
              drop_d = drop_q + 16'd1;
            end else begin
              drop_d = drop_q;
            end
          end else begin
            state_d = S_PRESENT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ndv_d   = 1'b1;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      mode_q  <= 2'd0;
      word_q  <= {W{1'b0}};
      lfsr_q  <= LFSR_SEED;
      dout_q  <= {W{1'b0}};
      ndv_q   <= 1'b1;
      drop_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      lfsr_q  <= lfsr_d;
      dout_q  <= dout_d;
      ndv_q   <= ndv_d;
      drop_q  <= drop_d;
    end
  end

  assign nDValid   = ndv_q;
  assign dOut      = dout_q;
  assign dropCount = drop_q;

endmodule

// File: tb/tb_trace_pattern_gen.sv
// Bench for trace_pattern_gen: an 8-bit and a 16-bit instance share stimulus and are
// compared every cycle against a slot/word-index model, plus vector tables and corner sequences.
module tb_trace_pattern_gen;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        nRst;
  logic        enable;
  logic [1:0]  mode;
  logic        dReady;
  logic        nd8, nd16;
  logic [7:0]  dout8;
  logic [15:0] dout16;
  logic [15:0] drop8, drop16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trace_pattern_gen #(.OUTPUT_BUS_WIDTH(8), .CLOCKFRQ(40), .DIVISOR(D), .LFSR_SEED(32'h0000_0001)) dut8 (
    .clk(clk), .nRst(nRst), .enable(enable), .mode(mode), .dReady(dReady),
    .nDValid(nd8), .dOut(dout8), .dropCount(drop8));

  trace_pattern_gen #(.OUTPUT_BUS_WIDTH(16), .CLOCKFRQ(40), .DIVISOR(D), .LFSR_SEED(32'h0000_0001)) dut16 (
    .clk(clk), .nRst(nRst), .enable(enable), .mode(mode), .dReady(dReady),
    .nDValid(nd16), .dOut(dout16), .dropCount(drop16));

  // Reference model: running/presenting flags, slot phase, and word index k.
  bit          m_run, m_pres, m_nd;
  int          m_phase, m_k, m_drop;
  logic [1:0]  m_mode;
  logic [31:0] m_lfsr, m_d8, m_d16;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  function automatic logic [31:0] word_of(input logic [1:0] md, input int k, input int w, input logic [31:0] lf);
    logic [31:0] mask;
    int a;
    mask = (32'd1 << w) - 32'd1;
    a = k % 28;
    case (md)
      2'd0:    return (a < 26) ? 32'(65 + a) : ((a == 26) ? 32'd10 : 32'd13);
      2'd1:    return 32'(k) & mask;
      2'd2:    return lf & mask;
      default: return 32'd1 << (k % w);
    endcase
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_pres = 1'b0; m_nd = 1'b1;
    m_phase = 0; m_k = 0; m_drop = 0;
    m_mode = 2'd0; m_lfsr = 32'h0000_0001; m_d8 = 32'd0; m_d16 = 32'd0;
  endtask

  task automatic model_edge();
    bit tick;
    if (!enable) begin
      m_run = 1'b0; m_pres = 1'b0; m_phase = 0; m_nd = 1'b1;
    end else if (!m_run) begin
      m_run = 1'b1; m_pres = 1'b0; m_phase = 0; m_nd = 1'b1;
      m_mode = mode; m_k = 0; m_lfsr = 32'h0000_0001;
    end else begin
      tick = (m_phase == D - 1);
      m_phase = (m_phase + 1) % D;
      if (m_pres) begin
        if (dReady) begin
          m_pres = 1'b0; m_nd = 1'b1; m_k++; m_lfsr = lfsr_step(m_lfsr);
        end else if (tick && m_drop < 65535) begin
          m_drop++;
        end
      end else if (tick) begin
        m_pres = 1'b1; m_nd = 1'b0;
        m_d8  = word_of(m_mode, m_k, 8, m_lfsr);
        m_d16 = word_of(m_mode, m_k, 16, m_lfsr);
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_nd8",    {31'd0, nd8},     {31'd0, m_nd});
    check("m_nd16",   {31'd0, nd16},    {31'd0, m_nd});
    check("m_dout8",  {24'd0, dout8},   m_d8);
    check("m_dout16", {16'd0, dout16},  m_d16);
    check("m_drop8",  {16'd0, drop8},   32'(m_drop));
    check("m_drop16", {16'd0, drop16},  32'(m_drop));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_model();
    end
  endtask

  task automatic wait_low(input string nm, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (nd8 !== 1'b0 && n < 40);
    check(nm, {31'd0, nd8}, 32'd0);
  endtask

  typedef struct {
    bit         en;
    logic [1:0] md;
    bit         rdy;
    int         n;
    logic [7:0] dout;
    bit         nd;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int g;
    logic [31:0] exp_w;
    logic [15:0] prbs_exp [4];

    tbl[0]  = '{1'b1, 2'd0, 1'b1, 4,  8'd0,  1'b1, 16'd0};
    tbl[1]  = '{1'b1, 2'd0, 1'b1, 1,  8'd65, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 2'd0, 1'b1, 1,  8'd65, 1'b1, 16'd0};
    tbl[3]  = '{1'b1, 2'd0, 1'b1, 3,  8'd66, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 2'd0, 1'b1, 1,  8'd66, 1'b1, 16'd0};
    tbl[5]  = '{1'b1, 2'd0, 1'b1, 3,  8'd67, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 12, 8'd67, 1'b0, 16'd3};
    tbl[7]  = '{1'b1, 2'd0, 1'b1, 1,  8'd67, 1'b1, 16'd3};
    tbl[8]  = '{1'b1, 2'd0, 1'b1, 3,  8'd68, 1'b0, 16'd3};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 1,  8'd68, 1'b1, 16'd3};
    tbl[10] = '{1'b1, 2'd3, 1'b1, 5,  8'd1,  1'b0, 16'd3};
    tbl[11] = '{1'b1, 2'd1, 1'b1, 1,  8'd1,  1'b1, 16'd3};
    tbl[12] = '{1'b1, 2'd1, 1'b1, 3,  8'd2,  1'b0, 16'd3};
    tbl[13] = '{1'b1, 2'd2, 1'b1, 1,  8'd2,  1'b1, 16'd3};
    tbl[14] = '{1'b1, 2'd2, 1'b1, 3,  8'd4,  1'b0, 16'd3};
    prbs_exp[0] = 16'd1; prbs_exp[1] = 16'd3; prbs_exp[2] = 16'd6; prbs_exp[3] = 16'd13;

    nRst = 1'b0; enable = 1'b0; mode = 2'd0; dReady = 1'b1;
    model_reset();
    #12;
    check("rst_nd",   {31'd0, nd8},    32'd1);
    check("rst_dout", {16'd0, dout16}, 32'd0);
    check("rst_drop", {16'd0, drop8},  32'd0);
    nRst = 1'b1;
    cyc(2);

    for (int r = 0; r < 15; r++) begin
      enable = tbl[r].en; mode = tbl[r].md; dReady = tbl[r].rdy;
      cyc(tbl[r].n);
      check($sformatf("row%0d_dout", r), {24'd0, dout8}, {24'd0, tbl[r].dout});
      check($sformatf("row%0d_nd", r),   {31'd0, nd8},   {31'd0, tbl[r].nd});
      check($sformatf("row%0d_drop", r), {16'd0, drop8}, {16'd0, tbl[r].drop});
    end

    // ASCII run: latency from enable, then 29 words at one per slot.
    enable = 1'b0; cyc(2);
    enable = 1'b1; mode = 2'd0; dReady = 1'b1;
    wait_low("lat_valid", g);
    check("latency", 32'(g), 32'(D + 1));
    for (int w = 0; w < 29; w++) begin
      exp_w = (w < 26) ? 32'(65 + w) : ((w == 26) ? 32'd10 : ((w == 27) ? 32'd13 : 32'd65));
      check($sformatf("ascii_w%0d", w), {24'd0, dout8}, exp_w);
      wait_low("ascii_valid", g);
      check("ascii_gap", 32'(g), 32'(D));
    end

    // Count mode, 260 words: wraps at 256 on the 8-bit instance.
    enable = 1'b0; cyc(1);
    enable = 1'b1; mode = 2'd1;
    for (int w = 0; w < 260; w++) begin
      wait_low("cnt_valid", g);
      check("cnt_w8", {24'd0, dout8}, 32'(w % 256));
    end
    check("cnt_drop", {16'd0, drop8}, 32'd3);

    // PRBS from seed 1; mode input toggled mid-run must not matter.
    enable = 1'b0; cyc(1);
    enable = 1'b1; mode = 2'd2;
    for (int w = 0; w < 4; w++) begin
      wait_low("prbs_valid", g);
      check($sformatf("prbs_w%0d", w), {16'd0, dout16}, {16'd0, prbs_exp[w]});
      if (w == 1) mode = 2'd3;
    end

    // Async reset mid-PRESENT after some drops.
    dReady = 1'b0;
    wait_low("rstp_valid", g);
    cyc(2 * D);
    check("rstp_drop_pre", {16'd0, drop8}, 32'd5);
    #2 nRst = 1'b0;
    #1;
    model_reset();
    check("rstp_nd",     {31'd0, nd8},    32'd1);
    check("rstp_dout8",  {24'd0, dout8},  32'd0);
    check("rstp_dout16", {16'd0, dout16}, 32'd0);
    check("rstp_drop",   {16'd0, drop16}, 32'd0);
    #2 nRst = 1'b1;
    dReady = 1'b1;
    cyc(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 59) != 0);
      mode   = 2'($urandom_range(0, 3));
      dReady = ($urandom_range(0, 2) != 0);
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_pattern_gen.md
TRACE_PATTERN_GEN -- requirements
Module: trace_pattern_gen

Interface
REQ-001 SHALL have parameter OUTPUT_BUS_WIDTH, default 8, output word width; legal 8..32.
REQ-002 SHALL have parameter CLOCKFRQ, default 240000000, oscillator frequency in Hz.
REQ-003 SHALL have parameter DIVISOR, default CLOCKFRQ/10, clocks per word slot; legal >= 2.
REQ-004 SHALL have parameter LFSR_SEED, default 32'h0000_0001, nonzero PRBS start value.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  input  1  generator run; low returns to IDLE.
REQ-008 SHALL have port mode  input  2  pattern select, sampled only on IDLE exit.
REQ-009 SHALL have port dReady  input  1  consumer ready, active-high.
REQ-010 SHALL have port nDValid  output  1  data valid strobe, active-low, registered.
REQ-011 SHALL have port dOut  output  OUTPUT_BUS_WIDTH  data word, registered.
REQ-012 SHALL have port dropCount  output  16  slots missed because consumer stalled, saturating.

Function
REQ-013 SHALL implement states IDLE, WAIT, PRESENT.
REQ-014 IDLE: enable high -> latch mode into activeMode, load pattern start value, clear slot counter, go WAIT.
REQ-015 Slot counter SHALL count 0..DIVISOR-1 in WAIT and PRESENT, wrapping; tick = counter at DIVISOR-1.
REQ-016 WAIT: on tick, SHALL drive dOut with current pattern word and nDValid=0 on the next edge, go PRESENT.
REQ-017 PRESENT: dOut and nDValid SHALL hold stable until an edge where dReady=1 (transfer).
REQ-018 On transfer edge: nDValid=1 next cycle, pattern advances one step, go WAIT; dOut holds last value.
REQ-019 Tick while PRESENT and dReady=0 SHALL increment dropCount (saturate 16'hFFFF); no word queued.
REQ-020 Tick coinciding with transfer SHALL count as drop-free; the slot is consumed by the pending word, next word waits for following tick.
REQ-021 activeMode 0 (ASCII): 65..90, then 10, then 13, then 65; zero-extended to width.
REQ-022 activeMode 1 (count): 0,1,2,... wrapping at 2^OUTPUT_BUS_WIDTH.
REQ-023 activeMode 2 (PRBS): 32-bit Fibonacci LFSR, poly x^32+x^22+x^2+x+1, start LFSR_SEED, one shift per word, dOut = low OUTPUT_BUS_WIDTH bits.
REQ-024 activeMode 3 (walking one): 1, then rotate left by 1 per word, wrapping MSB->LSB.
REQ-025 enable low in any state SHALL force IDLE on next edge, nDValid=1, slot counter 0; dropCount retained; pending word discarded.
REQ-026 mode changes while not IDLE SHALL be ignored until next IDLE exit.
REQ-027 Latency enable rise -> first nDValid=0 SHALL be DIVISOR+1 clocks.

Reset
REQ-028 nRst low SHALL asynchronously set state IDLE, nDValid=1, dOut=0, dropCount=0, slot counter 0, activeMode 0, LFSR=LFSR_SEED.
REQ-029 nRst deassertion SHALL take effect on the next clk edge; reset mid-PRESENT drops the word without counting.

Verification
REQ-030 DIVISOR=4, mode 0, dReady=1: dOut sequence 65..90,10,13,65; nDValid low one cycle every 4 clocks; first low 5 clocks after enable.
REQ-031 mode 1, W=8, dReady=1, 260 words: dOut 0..255 then 0..3; dropCount=0.
REQ-032 mode 2, seed 1, W=16: first 4 words match reference LFSR model; mode toggled mid-run has no effect.
REQ-033 dReady=0 for 3*DIVISOR clocks while PRESENT: dOut/nDValid stable, dropCount=3; after dReady=1 word accepted, next word is successor.
REQ-034 enable dropped during PRESENT then reraised with mode 3: nDValid=1 next cycle, restart at 1, dropCount unchanged.
REQ-035 nRst pulsed asynchronously between edges mid-PRESENT: outputs reset immediately, dropCount=0, dOut=0.
